// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq.
// The ovf signal exists only when WADD_OVF_EN is defined.
interface wide_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int N = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef WADD_OVF_EN
    logic         ovf;
`endif

    // Source/consumer side.
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef WADD_OVF_EN
        , input ovf
`endif
    );

    // Sequencer side.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef WADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-limb add/subtract sequencer: one 16-bit carry-lookahead slice, LSB limb first.
// Optional feature macro WADD_OVF_EN adds a registered signed-overflow flag (ovf).
module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int N     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [N-1:0]       a_r;
    logic [N-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [N-1:0]       sum_r;
    logic               cout_r;
    logic               last_s;
    logic [15:0]        limb_a_s;
    logic [15:0]        limb_b_s;
    logic [17:0]        slice_s;
`ifdef WADD_OVF_EN
    logic               ovf_r;
`endif

    // 16-bit slice from four 4-bit groups; returns {carry out, carry into bit 15, sum}.
    function automatic logic [17:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                          input logic cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        logic [16:0] c;
        logic [15:0] s;
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        // Group carries are flattened sum-of-products of cin; no chaining between groups.
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k]   | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        c[16] = gc[4];
        s = p ^ c[15:0];
        return {c[16], c[15], s};
    endfunction

    assign last_s   = (idx_r == IDX_W'(WORDS - 1));
    assign limb_a_s = a_r[32'(idx_r) * 16 +: 16];
    assign limb_b_s = b_r[32'(idx_r) * 16 +: 16];
    assign slice_s  = cla16(limb_a_s, limb_b_s, carry_r);

    // Next-state selection for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_nxt_s = RUN;
                else              state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_nxt_s = IDLE;
                else               state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Operand capture, per-limb accumulation and final flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
`ifdef WADD_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b ^ {N{bus.sub}};
                        carry_r <= bus.sub;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[32'(idx_r) * 16 +: 16] <= slice_s[15:0];
                    carry_r                      <= slice_s[17];
                    if (last_s) begin
                        cout_r <= slice_s[17];
`ifdef WADD_OVF_EN
                        ovf_r  <= slice_s[17] ^ slice_s[16];
`endif
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
`ifdef WADD_OVF_EN
    assign bus.ovf       = ovf_r;
`endif
endmodule
